pipeline_credit_sink: RTL



---
 rtl/pipeline_credit_sink_pkg.sv | 22 ++
 rtl/pipeline_credit_sink_if.sv | 28 ++
 rtl/pipeline_credit_sink_sync_fifo_fwft.sv | 57 +++++
 rtl/pipeline_registers.sv | 25 ++
 rtl/pipeline_credit_sink.sv | 79 +++++++
 5 files changed

// File: rtl/pipeline_credit_sink_pkg.sv
// Shared constants and width helpers for the pipeline credit sink.
package pipeline_credit_sink_pkg;

  // Bits needed to index (or count down from value-1); never less than 1.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // Credits and occupancy must reach DEPTH itself, hence one extra bit.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int DEFAULT_BIT_WIDTH        = 10;
  localparam int DEFAULT_NUMBER_OF_STAGES = 5;
  localparam int DEFAULT_DEPTH            = 8;
  localparam int DEFAULT_ADDR_WIDTH       = clog2_min1(DEFAULT_DEPTH);

endpackage

// File: rtl/pipeline_credit_sink_if.sv
// Launcher, pipeline-exit and downstream signals of the credit sink.
interface pipeline_credit_sink_if
  import pipeline_credit_sink_pkg::*;
#(
  parameter int BIT_WIDTH  = DEFAULT_BIT_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
  logic                  send_in;
  logic                  can_send;
  logic                  pipe_valid;
  logic [BIT_WIDTH-1:0]  pipe_data;
  logic [BIT_WIDTH-1:0]  deq_data;
  logic                  deq_valid;
  logic                  deq_ready;
  logic [ADDR_WIDTH:0]   count;
  logic                  err_credit;
  logic                  err_overflow;

  modport slave (
    input  send_in, pipe_valid, pipe_data, deq_ready,
    output can_send, deq_data, deq_valid, count, err_credit, err_overflow
  );

  modport master (
    output send_in, pipe_valid, pipe_data, deq_ready,
    input  can_send, deq_data, deq_valid, count, err_credit, err_overflow
  );
endinterface

// File: rtl/pipeline_credit_sink_sync_fifo_fwft.sv
// First-word fall-through FIFO; a push on full is accepted only alongside a pop.
module sync_fifo_fwft
  import pipeline_credit_sink_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_BIT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = clog2_min1(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  drop
);
  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  full;
  logic                  do_pop;
  logic                  wr_en;

  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);
  assign do_pop = pop & ~empty;
  assign wr_en  = push & (~full | do_pop);
  assign drop   = push & full & ~do_pop;
  assign rdata  = mem[rd_ptr];

  // Storage carries no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; count tracks the net of push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_en, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pipeline_registers.sv
// Fixed-latency register chain with no reset; STAGES=0 is a plain wire.
module pipeline_registers #(
  parameter int WIDTH  = 11,
  parameter int STAGES = 5
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (STAGES == 0) begin : g_wire
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] stage [STAGES];

      // Shift the word one stage further each cycle.
      always_ff @(posedge clk) begin
        stage[0] <= d;
        for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end

      assign q = stage[STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/pipeline_credit_sink.sv
// Credit-returning sink at the end of an unbackpressured pipeline.
module pipeline_credit_sink
  import pipeline_credit_sink_pkg::*;
#(
  parameter int BIT_WIDTH        = DEFAULT_BIT_WIDTH,
  parameter int NUMBER_OF_STAGES = DEFAULT_NUMBER_OF_STAGES,
  parameter int DEPTH            = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH       = clog2_min1(DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_credit_sink_if.slave sink
);
  localparam int CW      = count_width(ADDR_WIDTH);
  localparam int DRAIN_W = clog2_min1(NUMBER_OF_STAGES + 1);
  localparam logic [CW-1:0]      CREDIT_INIT = CW'(DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT  = DRAIN_W'(NUMBER_OF_STAGES);

  logic [CW-1:0]      credits;
  logic [DRAIN_W-1:0] drain;
  logic               drain_done;
  logic               can_send;
  logic               take;
  logic               give;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_drop;

  // The pipeline keeps stale valids across reset; ignore them until it has flushed.
  assign drain_done = (drain == '0);
  assign can_send   = ~rst & (credits != '0) & drain_done;
  assign take       = sink.send_in & can_send;
  assign push       = sink.pipe_valid & drain_done;
  assign pop        = ~fifo_empty & sink.deq_ready;
  assign give       = pop;

  assign sink.can_send  = can_send;
  assign sink.deq_valid = ~fifo_empty;

  // Drain window: count down once per cycle after reset, holding at zero.
  always_ff @(posedge clk) begin
    if (rst)              drain <= DRAIN_INIT;
    else if (!drain_done) drain <= drain - DRAIN_W'(1);
  end

  // Credits leave with each accepted send and come back with each pop.
  always_ff @(posedge clk) begin
    if (rst) credits <= CREDIT_INIT;
    else     credits <= credits - CW'(take) + CW'(give);
  end

  // Sticky protocol-violation flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sink.err_credit   <= 1'b0;
      sink.err_overflow <= 1'b0;
    end else begin
      if (sink.send_in & ~can_send) sink.err_credit   <= 1'b1;
      if (fifo_drop)                sink.err_overflow <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH      (BIT_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (sink.pipe_data),
    .pop   (pop),
    .rdata (sink.deq_data),
    .count (sink.count),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );
endmodule
